// File: rtl/fsoc_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsoc_rst_pkg                                                  |
// | Description : Shared types and constants for the FazyRV SoC reset          |
// |               sequencer (state enum, boot-counter width and ceiling).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fsoc_rst_pkg;

  // Sequencer states: core held in reset, core running, one-cycle watchdog hit.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    WDT  = 2'd2
  } rst_state_e;

  localparam int                   BOOTCNT_W   = 4;
  localparam logic [BOOTCNT_W-1:0] BOOTCNT_MAX = 4'd15;

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rst_sync                                                      |
// | Description : Two-flop reset synchronizer. Asserts asynchronously,         |
// |               releases synchronously on the second rising clk edge.        |
// | Ports       : clk  - destination clock                                     |
// |               arst - raw active-high reset (asynchronous)                  |
// |               srst - synchronized active-high reset                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rst_sync (
  input  logic clk,
  input  logic arst,
  output logic srst
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= 1'b0;
      sync <= meta;
    end
  end

  assign srst = sync;

endmodule
`default_nettype wire

// File: rtl/fsoc_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsoc_rst_seq                                                  |
// | Description : Reset sequencer and heartbeat watchdog for the FazyRV SoC.   |
// |               Synchronizes the warm-boot reset, holds the core in reset    |
// |               for HOLD_CYCLES, then watches a firmware heartbeat bit and   |
// |               forces a core-only reset when it stops toggling.             |
// | Macro       : FSOC_RST_SEQ_WDT_EN - when defined, builds the heartbeat     |
// |               watchdog and WDT state; otherwise RUN is left only by reset. |
// | Ports       : clk        - fabric clock (rising edge)                      |
// |               reset      - raw active-high async reset                     |
// |               hb_i       - firmware heartbeat (clk domain)                 |
// |               rst_n_o    - active-low core reset                           |
// |               wdt_fire_o - one-cycle pulse on watchdog expiry              |
// |               boot_cnt_o - saturating count of watchdog resets             |
// |               running_o  - high while in RUN                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fsoc_rst_seq
  import fsoc_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int WDT_CYCLES  = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hb_i,
  output logic                 rst_n_o,
  output logic                 wdt_fire_o,
  output logic [BOOTCNT_W-1:0] boot_cnt_o,
  output logic                 running_o
);

  localparam int CNT_RANGE = (HOLD_CYCLES > WDT_CYCLES) ? HOLD_CYCLES : WDT_CYCLES;
  localparam int CNT_W     = (CNT_RANGE > 2) ? $clog2(CNT_RANGE) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             srst;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_q;
  logic             running_q;

  rst_sync u_rst_sync (
    .clk  (clk),
    .arst (reset),
    .srst (srst)
  );

`ifdef FSOC_RST_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic                 hb_q;
  logic                 toggle;
  logic                 armed_q, armed_d;
  logic [BOOTCNT_W-1:0] boot_q, boot_d;
  logic                 fire_q;

  // hb_q follows hb_i every cycle in every state, so on entry to RUN it
  // already holds the level seen on the entry edge; no reset value needed.
  always_ff @(posedge clk) begin
    hb_q <= hb_i;
  end

  assign toggle = hb_i ^ hb_q;
`else
  logic unused_hb;
  assign unused_hb = hb_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef FSOC_RST_SEQ_WDT_EN
    armed_d = armed_q;
    boot_d  = boot_q;
`endif
    case (state_q)
      HOLD: begin
`ifdef FSOC_RST_SEQ_WDT_EN
        armed_d = 1'b0;
`endif
        if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
`ifdef FSOC_RST_SEQ_WDT_EN
        // A heartbeat edge always wins over a terminal count in the same cycle.
        if (toggle) begin
          armed_d = 1'b1;
          cnt_d   = '0;
        end else if (armed_q) begin
          if (cnt_q == WDT_LAST) begin
            state_d = WDT;
            cnt_d   = '0;
            armed_d = 1'b0;
            boot_d  = (boot_q == BOOTCNT_MAX) ? boot_q : boot_q + BOOTCNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        cnt_d = '0;
`endif
      end

`ifdef FSOC_RST_SEQ_WDT_EN
      WDT: begin
        state_d = HOLD;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
`endif

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up exactly
  // with the state register.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      rst_n_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= (state_d == RUN);
      running_q <= (state_d == RUN);
    end
  end

`ifdef FSOC_RST_SEQ_WDT_EN
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      armed_q <= 1'b0;
      boot_q  <= '0;
      fire_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      boot_q  <= boot_d;
      fire_q  <= (state_d == WDT);
    end
  end

  assign wdt_fire_o = fire_q;
  assign boot_cnt_o = boot_q;
`else
  assign wdt_fire_o = 1'b0;
  assign boot_cnt_o = '0;
`endif

  assign rst_n_o   = rst_n_q;
  assign running_o = running_q;

endmodule
`default_nettype wire

// File: tb/tb_fsoc_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fsoc_rst_seq                                               |
// | Description : Self-checking bench for fsoc_rst_seq. A timestamp-based      |
// |               reference model (run start edge, last heartbeat edge) checks |
// |               every cycle; scenario tables and hand sequences cover the    |
// |               power-up, timeout, same-cycle toggle and saturation cases.   |
// | Macro       : FSOC_RST_SEQ_WDT_EN - selects watchdog expectations.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fsoc_rst_seq;

  localparam int HOLD = 16;
  localparam int WDTC = 64;
`ifdef FSOC_RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif
  localparam int EXP_ONE = WDT_ON ? 1 : 0;
  localparam int EXP_LOW = WDT_ON ? HOLD + 1 : 0;
  localparam int EXP_SAT_FIRES = WDT_ON ? 17 : 0;
  localparam int EXP_SAT_BOOT  = WDT_ON ? 15 : 0;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       hb    = 1'b0;
  logic       rst_n;
  logic       fire;
  logic [3:0] boot;
  logic       running;

  fsoc_rst_seq #(
    .HOLD_CYCLES (HOLD),
    .WDT_CYCLES  (WDTC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hb_i       (hb),
    .rst_n_o    (rst_n),
    .wdt_fire_o (fire),
    .boot_cnt_o (boot),
    .running_o  (running)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state, expressed as edge timestamps.
  int edge_n    = 0;
  bit m_reset   = 1'b1;
  int run_start = 0;
  bit m_armed   = 1'b0;
  int last_tog  = 0;
  int m_boot    = 0;
  bit prev_hb   = 1'b0;
  bit exp_fire  = 1'b0;
  bit exp_run   = 1'b0;
  int fire_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge(input bit h);
    edge_n++;
    exp_fire = 1'b0;
    if (!m_reset) begin
      if (edge_n == run_start) begin
        m_armed = 1'b0;
      end else if (edge_n > run_start) begin
`ifdef FSOC_RST_SEQ_WDT_EN
        if (h != prev_hb) begin
          m_armed  = 1'b1;
          last_tog = edge_n;
        end else if (m_armed && (edge_n - last_tog == WDTC)) begin
          exp_fire  = 1'b1;
          m_armed   = 1'b0;
          if (m_boot < 15) m_boot++;
          run_start = edge_n + 1 + HOLD;
        end
`endif
      end
    end
    prev_hb = h;
    exp_run = !m_reset && (edge_n >= run_start);
  endtask

  task automatic step(input bit h);
    hb = h;
    @(posedge clk);
    model_edge(h);
    #1;
    chk("rst_n", rst_n, exp_run);
    chk("running", running, exp_run);
    chk("wdt_fire", fire, exp_fire);
    chk("boot_cnt", boot, m_boot);
    if (fire === 1'b1) fire_cnt++;
  endtask

  task automatic apply_reset(input int cycles);
    reset   = 1'b1;
    m_reset = 1'b1;
    m_boot  = 0;
    #1;
    chk("async_rst_n", rst_n, 0);
    chk("async_boot", boot, 0);
    chk("async_running", running, 0);
    repeat (cycles) step(hb);
    reset     = 1'b0;
    m_reset   = 1'b0;
    run_start = edge_n + HOLD + 2;
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (running !== 1'b1 && n < 200) begin
      step(hb);
      n++;
    end
    chk(name, running, 1);
  endtask

  typedef struct {
    bit single;
    int period;
    int cycles;
    int exp_fires;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    int base;
    int n;
    int tog;
    int first_fire;
    int low;
    int rate;
    bit t;

    tbl[0] = '{single: 1'b0, period: 50,  cycles: 1000,     exp_fires: 0};
    tbl[1] = '{single: 1'b0, period: 63,  cycles: 500,      exp_fires: 0};
    tbl[2] = '{single: 1'b0, period: 0,   cycles: 10*WDTC,  exp_fires: 0};
    tbl[3] = '{single: 1'b1, period: 0,   cycles: 150,      exp_fires: EXP_ONE};
    tbl[4] = '{single: 1'b0, period: 100, cycles: 300,      exp_fires: 3*EXP_ONE};

    #2;
    // Power-up
    apply_reset(5);
    base = edge_n;
    n = 0;
    while (rst_n !== 1'b1 && n < 40) begin
      step(hb);
      n++;
    end
    chk("powerup_rise_edge", edge_n - base, HOLD + 2);
    chk("powerup_running", running, 1);
    chk("powerup_boot", boot, 0);

    // Scenario table
    for (int r = 0; r < 5; r++) begin
      apply_reset(2);
      wait_run("tbl_run");
      fire_cnt = 0;
      for (int i = 0; i < tbl[r].cycles; i++) begin
        if (tbl[r].single) t = (i == 0);
        else               t = (tbl[r].period > 0) && (i % tbl[r].period == 0);
        step(t ? ~hb : hb);
      end
      chk($sformatf("tbl%0d_fires", r), fire_cnt, tbl[r].exp_fires);
    end

    // Timeout after a single heartbeat edge
    apply_reset(3);
    wait_run("to_run");
    step(hb);
    step(hb);
    step(~hb);
    tog = edge_n;
    fire_cnt = 0;
    first_fire = -1;
    low = 0;
    for (int i = 0; i < 150; i++) begin
      step(hb);
      if (fire === 1'b1 && first_fire < 0) first_fire = edge_n;
      if (rst_n !== 1'b1) low++;
    end
    chk("timeout_fires", fire_cnt, EXP_ONE);
    chk("timeout_low_cycles", low, EXP_LOW);
    chk("timeout_boot", boot, EXP_ONE);
`ifdef FSOC_RST_SEQ_WDT_EN
    chk("timeout_latency", first_fire - tog, WDTC);
`endif

    // Toggle coinciding with terminal count
    apply_reset(3);
    wait_run("simul_run");
    step(~hb);
    fire_cnt = 0;
    repeat (WDTC - 1) step(hb);
    step(~hb);
    chk("simul_running", running, 1);
    chk("simul_fires", fire_cnt, 0);
    repeat (WDTC - 1) step(hb);
    chk("simul_no_early", fire_cnt, 0);
    step(hb);
    chk("simul_late_fire", fire_cnt, EXP_ONE);

    // Saturation of the boot counter, then reset during HOLD
    apply_reset(3);
    fire_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      wait_run("sat_run");
      step(~hb);
      repeat (WDTC) step(hb);
    end
    chk("sat_fires", fire_cnt, EXP_SAT_FIRES);
    chk("sat_boot", boot, EXP_SAT_BOOT);
    step(hb);
    step(hb);
    apply_reset(3);
    repeat (6) step(hb);
    chk("hold_not_running", running, 0);
    apply_reset(2);
    wait_run("after_abort_run");

    // Randomized heartbeat bursts
    apply_reset(2);
    for (int b = 0; b < 20; b++) begin
      case ($urandom_range(4))
        0:       rate = 0;
        1:       rate = 8;
        2:       rate = 40;
        3:       rate = 100;
        default: rate = 300;
      endcase
      for (int i = 0; i < 200; i++) begin
        t = (rate != 0) && ($urandom_range(rate - 1) == 0);
        step(t ? ~hb : hb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : timeout_guard
    #5000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/fsoc_rst_seq.md
# fsoc_rst_seq

Reset sequencer and heartbeat watchdog between the fabric's warm-boot reset source and the FazyRV SoC core. It takes the raw active-high reset from the WARMBOOT_wrapper RESET output and synchronizes it. It holds the core in reset for a programmable number of cycles and drives the core's active-low `rst_in`. Once the core runs, it watches a heartbeat bit the firmware toggles on one GPO line, and forces a core-only reset if the toggling stops.

## Interface

Parameters:
- `HOLD_CYCLES`, default 16: cycles `rst_n_o` stays low after synchronized reset release or after a watchdog reset; must be ≥ 2.
- `WDT_CYCLES`, default 1048576: heartbeat timeout in cycles; must be ≥ 2.

Ports:
- `clk`, input, 1: single fabric clock; all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset, from WARMBOOT_wrapper RESET.
- `hb_i`, input, 1: firmware heartbeat, wired to a core GPO bit (same `clk` domain).
- `rst_n_o`, output, 1: active-low core reset, wired to fsoc `rst_in`.
- `wdt_fire_o`, output, 1: one-cycle pulse when the watchdog expires.
- `boot_cnt_o`, output, 4: number of watchdog resets since `reset`; saturates at 15.
- `running_o`, output, 1: high while the FSM is in RUN.

## Operation

- Reset synchronizer: `reset` asserts the internal reset asynchronously. Deassertion passes through 2 flops on `clk`.
- While internal reset is active, outputs are held at `rst_n_o`=0, `wdt_fire_o`=0, `boot_cnt_o`=0 and `running_o`=0. Internal state is state=HOLD, cnt=0, armed=0 and hb_q=`hb_i`.
- FSM states: HOLD, RUN, WDT.
- HOLD: cnt increments every cycle. hb_q tracks `hb_i`, and armed stays 0. At cnt==HOLD_CYCLES-1 the FSM goes to RUN and clears cnt. `rst_n_o` is registered to 1 on that same edge.
- RUN: toggle = (`hb_i` != hb_q), and hb_q is updated every cycle.
  - On a toggle: armed←1 and cnt←0.
  - Otherwise, if armed: cnt increments.
  - If unarmed, cnt holds at 0. The watchdog never fires until the firmware produces its first heartbeat edge.
- RUN → WDT: armed, no toggle this cycle, and cnt==WDT_CYCLES-1.
  - If a toggle and terminal count occur in the same cycle, the toggle wins: cnt clears and the FSM stays in RUN.
- WDT: lasts exactly one cycle.
  - `wdt_fire_o`=1 and `rst_n_o`=0.
  - `boot_cnt_o` increments, saturating at 15.
  - armed←0, cnt←0, then the FSM goes to HOLD.
- `boot_cnt_o` is cleared only by `reset`.
- Counter width is $clog2(max(HOLD_CYCLES, WDT_CYCLES)). The shared counter never wraps: it is cleared on every state change.
- All outputs are registered. `rst_n_o` is also forced low asynchronously by internal reset.

## Timing

- `reset` rising: `rst_n_o` goes low immediately (asynchronous), with no clock required.
- `reset` falling: internal reset releases at the 2nd rising edge. `rst_n_o` rises at rising edge HOLD_CYCLES+2 after `reset` falls. With defaults, that is edge 18.
- Watchdog latency: the last heartbeat toggle is seen at edge T. `wdt_fire_o` is high during cycle T+WDT_CYCLES, and `rst_n_o` is low from that edge.
- After a watchdog reset, `rst_n_o` is low for HOLD_CYCLES+1 cycles: the WDT cycle plus HOLD.
- `reset` asserted mid-RUN or mid-HOLD aborts immediately and everything returns to reset values, including `boot_cnt_o`.
- `running_o` is high exactly while the state is RUN.

## Configuration

- `FSOC_RST_SEQ_WDT_EN` defined: the watchdog logic and the WDT state are compiled in, as described above.
- `FSOC_RST_SEQ_WDT_EN` undefined: no heartbeat logic is built.
  - RUN is left only via `reset`.
  - `wdt_fire_o` is tied to 0 and `boot_cnt_o` to 0.
  - `hb_i` is unused. HOLD behaviour and timing are unchanged.

## Structure

- Package `fsoc_rst_pkg` holds:
  - the `rst_state_e` enum: HOLD, RUN, WDT;
  - the `BOOTCNT_W` = 4 constant;
  - the `BOOTCNT_MAX` = 15 constant.
- Sub-module `rst_sync` is the 2-flop synchronizer: asynchronous assert, synchronous deassert, active-high input, active-high synchronized output.
- The top `fsoc_rst_seq` contains the FSM, the shared counter, heartbeat edge detection and the boot counter.

## Test plan

- Power-up: `reset`=1 for 5 cycles, then 0 → `rst_n_o`=0 through edge 17, then 1 from edge 18. `running_o` rises on the same edge. `boot_cnt_o`=0.
- Heartbeat kept alive (WDT_CYCLES=64): toggle `hb_i` every 50 cycles for 1000 cycles → no `wdt_fire_o` and `rst_n_o` stays 1.
- Timeout (WDT_CYCLES=64): one toggle, then hold `hb_i` → `wdt_fire_o` pulses once, 64 cycles after the toggle edge. `rst_n_o` is low for 17 cycles and `boot_cnt_o` reads 1.
- Never armed: no `hb_i` edges for 10×WDT_CYCLES → no fire. A simultaneous toggle at terminal count → stays in RUN with cnt=0.
- Saturation and reset abort: force 17 timeouts → `boot_cnt_o`=15. Asserting `reset` mid-HOLD → `rst_n_o` stays 0 asynchronously and `boot_cnt_o` returns to 0.
- Built without `FSOC_RST_SEQ_WDT_EN`: repeat the timeout test → `wdt_fire_o` is never asserted and `rst_n_o` stays 1.
